// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - FSM state enum, default cache geometry and address field-width helpers
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_WPB      = 4;
  localparam int DEF_NUM_SETS = 8;
  localparam int DEF_WAYS     = 2;

  function automatic int off_w(input int wpb);
    return $clog2(wpb);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int wpb, input int num_sets);
    return addr_w - $clog2(wpb) - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/assoc_cache_if.sv
// rtl/assoc_cache_if.sv - CPU and memory side signals of the cache, slave = cache, master = environment
interface assoc_cache_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WPB    = DEF_WPB
);

  logic                    cpu_rd;
  logic                    cpu_wr;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [DATA_W-1:0]       cpu_wdata;
  logic [DATA_W-1:0]       cpu_rdata;
  logic                    stall;

  logic                    mem_rd_req;
  logic                    mem_wr_req;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W*WPB-1:0]   mem_rdata;
  logic                    mem_ack;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, stall,
    output mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, stall,
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cache_way.sv
// rtl/cache_way.sv - one cache way: valid/tag/data arrays with a lookup port and a fill/word-write port
module cache_way
  import cache_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WPB      = DEF_WPB,
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int TAG_W    = tag_w(DEF_ADDR_W, DEF_WPB, DEF_NUM_SETS),
  parameter int OFF_W    = off_w(WPB),
  parameter int IDX_W    = idx_w(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      lk_idx_i,
  input  logic [TAG_W-1:0]      lk_tag_i,
  input  logic [OFF_W-1:0]      lk_off_i,
  output logic                  lk_valid_o,
  output logic                  lk_hit_o,
  output logic [DATA_W-1:0]     lk_word_o,
  input  logic                  fill_en_i,
  input  logic [IDX_W-1:0]      fill_idx_i,
  input  logic [TAG_W-1:0]      fill_tag_i,
  input  logic [DATA_W*WPB-1:0] fill_data_i,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [OFF_W-1:0]      wr_off_i,
  input  logic [DATA_W-1:0]     wr_data_i
);

  logic [NUM_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [DATA_W*WPB-1:0] data_q [NUM_SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_data_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i*DATA_W +: DATA_W] <= wr_data_i;
    end
  end

  assign lk_valid_o = valid_q[lk_idx_i];
  assign lk_hit_o   = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
  assign lk_word_o  = data_q[lk_idx_i][lk_off_i*DATA_W +: DATA_W];

endmodule

// File: rtl/assoc_cache.sv
// rtl/assoc_cache.sv - 1/2-way set-associative write-through cache; CACHE_STATS_EN adds hit/miss counters
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WPB      = DEF_WPB,
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int WAYS     = DEF_WAYS
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CACHE_STATS_EN
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
`endif
  assoc_cache_if.slave bus
);

  localparam int OFF_W = off_w(WPB);
  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(ADDR_W, WPB, NUM_SETS);

  state_t              state_q;
  logic                mem_rd_req_q;
  logic                mem_wr_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                victim_q;
  logic                victim_d;

  logic [OFF_W-1:0]    cpu_off;
  logic [IDX_W-1:0]    cpu_idx;
  logic [TAG_W-1:0]    cpu_tag;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;

  logic [WAYS-1:0]     way_hit;
  logic [WAYS-1:0]     way_valid;
  logic [WAYS-1:0]     way_fill;
  logic [WAYS-1:0]     way_wr;
  logic [DATA_W-1:0]   way_word [WAYS];

  logic                hit;
  logic                hit_way;
  logic [DATA_W-1:0]   hit_word;
  logic                lru_rd;
  logic                rd_hit;
  logic                rd_miss;
  logic                fill_en;
  logic                word_wr_en;
  logic                stall;

  assign cpu_off  = bus.cpu_addr[OFF_W-1:0];
  assign cpu_idx  = bus.cpu_addr[OFF_W +: IDX_W];
  assign cpu_tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign fill_idx = mem_addr_q[OFF_W +: IDX_W];
  assign fill_tag = mem_addr_q[ADDR_W-1 -: TAG_W];

  // A write in IDLE always wins over a simultaneous read.
  assign rd_hit     = (state_q == IDLE) && bus.cpu_rd && !bus.cpu_wr && hit;
  assign rd_miss    = (state_q == IDLE) && bus.cpu_rd && !bus.cpu_wr && !hit;
  assign fill_en    = (state_q == REFILL) && bus.mem_ack && !rst;
  assign word_wr_en = (state_q == WRITE) && bus.mem_ack && !rst;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_fill[w] = fill_en && (victim_q == 1'(w));
    assign way_wr[w]   = word_wr_en && way_hit[w];

    cache_way #(
      .DATA_W   (DATA_W),
      .WPB      (WPB),
      .NUM_SETS (NUM_SETS),
      .TAG_W    (TAG_W),
      .OFF_W    (OFF_W),
      .IDX_W    (IDX_W)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .lk_idx_i    (cpu_idx),
      .lk_tag_i    (cpu_tag),
      .lk_off_i    (cpu_off),
      .lk_valid_o  (way_valid[w]),
      .lk_hit_o    (way_hit[w]),
      .lk_word_o   (way_word[w]),
      .fill_en_i   (way_fill[w]),
      .fill_idx_i  (fill_idx),
      .fill_tag_i  (fill_tag),
      .fill_data_i (bus.mem_rdata),
      .wr_en_i     (way_wr[w]),
      .wr_idx_i    (cpu_idx),
      .wr_off_i    (cpu_off),
      .wr_data_i   (bus.cpu_wdata)
    );
  end

  always_comb begin
    hit      = 1'b0;
    hit_way  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit      = 1'b1;
        hit_way  = 1'(w);
        hit_word = way_word[w];
      end
    end
  end

  // Invalid ways are filled lowest first; only a full set consults the LRU bit.
  always_comb begin
    victim_d = lru_rd;
    if (!way_valid[0]) begin
      victim_d = 1'b0;
    end else if ((WAYS > 1) && !way_valid[WAYS-1]) begin
      victim_d = 1'b1;
    end
  end

  if (WAYS > 1) begin : g_lru
    logic [NUM_SETS-1:0] lru_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        lru_q <= '0;
      end else if (fill_en) begin
        lru_q[fill_idx] <= ~victim_q;
      end else if (rd_hit || (word_wr_en && hit)) begin
        lru_q[cpu_idx] <= ~hit_way;
      end
    end

    assign lru_rd = lru_q[cpu_idx];
  end else begin : g_no_lru
    assign lru_rd = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_wr) begin
            state_q      <= WRITE;
            mem_wr_req_q <= 1'b1;
            mem_addr_q   <= bus.cpu_addr;
            mem_wdata_q  <= bus.cpu_wdata;
          end else if (rd_miss) begin
            state_q      <= REFILL;
            mem_rd_req_q <= 1'b1;
            mem_addr_q   <= {bus.cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            victim_q     <= victim_d;
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            state_q      <= IDLE;
            mem_rd_req_q <= 1'b0;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            state_q      <= DONE;
            mem_wr_req_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      IDLE:          stall = bus.cpu_wr || rd_miss;
      REFILL, WRITE: stall = 1'b1;
      default:       stall = 1'b0;
    endcase
  end

  assign bus.cpu_rdata  = hit_word;
  assign bus.stall      = stall;
  assign bus.mem_rd_req = mem_rd_req_q;
  assign bus.mem_wr_req = mem_wr_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_hit && (hit_cnt_q != 16'hFFFF)) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (rd_miss && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
